// File: rtl/freelist_ctrl.sv
// Physical-register free pool for a 2-wide rename stage: speculative head, architectural head, tail.
// Latency: responses are combinational from the current head; alloc/free/flush update state at the next edge.
// Backpressure: none; over-requests and over-frees are dropped and raise a sticky error flag.
module freelist_ctrl #(
  parameter int PREG_NUM = 64,
  parameter int LREG_NUM = 32,
  parameter int FL_DEPTH = PREG_NUM - LREG_NUM,
  parameter int PREG_W   = $clog2(PREG_NUM),
  parameter int PW       = $clog2(FL_DEPTH) + 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              instr0_freelist_req_i,
  output logic [PREG_W-1:0] instr0_freelist_resp_o,
  input  logic              instr1_freelist_req_i,
  output logic [PREG_W-1:0] instr1_freelist_resp_o,
  output logic              freelist_can_alloc1_o,
  output logic              freelist_can_alloc2_o,
  output logic [PW-1:0]     freelist_count_o,
  input  logic              commit0_free_valid_i,
  input  logic [PREG_W-1:0] commit0_free_preg_i,
  input  logic              commit1_free_valid_i,
  input  logic [PREG_W-1:0] commit1_free_preg_i,
  input  logic              flush_valid_i,
  output logic              freelist_err_o
);

  localparam int IW = PW - 1;
  localparam logic [PW:0] DEPTH_W = (PW+1)'(FL_DEPTH);

  logic [PREG_W-1:0] entry_q [FL_DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     arch_head_q, arch_head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic              err_q, err_d;

  logic [PW-1:0]     count;
  logic [IW-1:0]     head1_idx;
  logic [1:0]        n_alloc;
  logic [1:0]        n_free;
  logic              free_ok;
  logic              wr0_en, wr1_en;
  logic [IW-1:0]     wr0_idx, wr1_idx;

  // Wrap bit makes tail - head the exact occupancy, 0..FL_DEPTH.
  assign count     = tail_q - head_q;
  assign head1_idx = head_q[IW-1:0] + IW'(1);
  assign n_alloc   = {1'b0, instr0_freelist_req_i} + {1'b0, instr1_freelist_req_i};
  assign n_free    = {1'b0, commit0_free_valid_i} + {1'b0, commit1_free_valid_i};

  // Only pregs currently handed out can come back; anything more would overrun slots
  // still holding free or rewindable entries.
  assign free_ok   = ({1'b0, count} + (PW+1)'(n_free)) <= DEPTH_W;

  // Valid commit slots pack into consecutive tail slots, slot 0 first.
  assign wr0_en    = commit0_free_valid_i && free_ok;
  assign wr1_en    = commit1_free_valid_i && free_ok;
  assign wr0_idx   = tail_q[IW-1:0];
  assign wr1_idx   = tail_q[IW-1:0] + IW'(commit0_free_valid_i);

  assign instr0_freelist_resp_o = entry_q[head_q[IW-1:0]];
  assign instr1_freelist_resp_o = instr0_freelist_req_i ? entry_q[head1_idx]
                                                        : entry_q[head_q[IW-1:0]];
  assign freelist_count_o       = count;
  assign freelist_can_alloc1_o  = (count != '0);
  assign freelist_can_alloc2_o  = (count >= PW'(2));
  assign freelist_err_o         = err_q;

  // Next pointer state: commit frees first, then either flush rewind or allocation.
  always_comb begin
    head_d      = head_q;
    arch_head_d = arch_head_q;
    tail_d      = tail_q;
    err_d       = err_q;
    if (n_free != 2'd0) begin
      if (free_ok) begin
        tail_d      = tail_q + PW'(n_free);
        arch_head_d = arch_head_q + PW'(n_free);
      end else begin
        err_d = 1'b1;
      end
    end
    if (flush_valid_i) begin
      head_d = arch_head_d;
    end else if (n_alloc != 2'd0) begin
      // Allocation sees only the occupancy from before this cycle's frees.
      if (count >= PW'(n_alloc)) begin
        head_d = head_q + PW'(n_alloc);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State registers and entry writes; reset refills the queue with the unmapped pregs.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      head_q      <= '0;
      arch_head_q <= '0;
      tail_q      <= {1'b1, {IW{1'b0}}};
      err_q       <= 1'b0;
      for (int i = 0; i < FL_DEPTH; i++) begin
        entry_q[i] <= PREG_W'(LREG_NUM + i);
      end
    end else begin
      head_q      <= head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
      err_q       <= err_d;
      if (wr0_en) entry_q[wr0_idx] <= commit0_free_preg_i;
      if (wr1_en) entry_q[wr1_idx] <= commit1_free_preg_i;
    end
  end

endmodule

// File: tb/tb_freelist_ctrl.sv
// Bench for freelist_ctrl: vector table, directed corner sequences, then random traffic
// checked against a queue-based model of the free pool and of in-flight allocations.
module tb_freelist_ctrl;

  localparam int PREG_W = 6;
  localparam int PW     = 6;

  logic              clock_i = 1'b0;
  logic              reset_i;
  logic              r0, r1, c0v, c1v, fl;
  logic [PREG_W-1:0] c0p, c1p;
  logic [PREG_W-1:0] resp0, resp1;
  logic              can1, can2, err;
  logic [PW-1:0]     count;

  int checks = 0;
  int errors = 0;

  // Model: free_q holds allocatable pregs in hand-out order; spec_q holds pregs handed
  // out but not yet committed, oldest first.
  int free_q[$];
  int spec_q[$];
  bit m_err;

  typedef struct {
    bit r0, r1;
    int e_resp0, e_resp1, e_count;
    bit e_can1, e_can2, e_err;
    bit chk_r1;
  } vec_t;
  vec_t vecs[6];

  freelist_ctrl dut (
    .clock_i                (clock_i),
    .reset_i                (reset_i),
    .instr0_freelist_req_i  (r0),
    .instr0_freelist_resp_o (resp0),
    .instr1_freelist_req_i  (r1),
    .instr1_freelist_resp_o (resp1),
    .freelist_can_alloc1_o  (can1),
    .freelist_can_alloc2_o  (can2),
    .freelist_count_o       (count),
    .commit0_free_valid_i   (c0v),
    .commit0_free_preg_i    (c0p),
    .commit1_free_valid_i   (c1v),
    .commit1_free_preg_i    (c1p),
    .flush_valid_i          (fl),
    .freelist_err_o         (err)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit a0, input bit a1, input bit v0, input int p0,
                       input bit v1, input int p1, input bit f);
    r0 = a0; r1 = a1; c0v = v0; c0p = PREG_W'(p0); c1v = v1; c1p = PREG_W'(p1); fl = f;
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    idle();
    tick();
    reset_i = 1'b0;
    #1;
  endtask

  task automatic model_init();
    free_q.delete();
    spec_q.delete();
    for (int i = 0; i < 32; i++) free_q.push_back(32 + i);
    m_err = 1'b0;
  endtask

  // One clock edge of the pool as seen from the rename/commit interfaces.
  task automatic model_step(input bit rst, input bit a0, input bit a1, input bit v0,
                            input int p0, input bit v1, input int p1, input bit f);
    int fsz;
    int na;
    int nf;
    if (rst) begin
      model_init();
      return;
    end
    fsz = free_q.size();
    na  = int'(a0) + int'(a1);
    nf  = int'(v0) + int'(v1);
    if (nf > 0) begin
      if (nf <= spec_q.size()) begin
        repeat (nf) void'(spec_q.pop_front());
        if (v0) free_q.push_back(p0);
        if (v1) free_q.push_back(p1);
      end else begin
        m_err = 1'b1;
      end
    end
    if (f) begin
      for (int i = spec_q.size() - 1; i >= 0; i--) free_q.push_front(spec_q[i]);
      spec_q.delete();
    end else if (na > 0) begin
      if (na <= fsz) begin
        repeat (na) spec_q.push_back(free_q.pop_front());
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  initial begin
    reset_i = 1'b0;
    idle();

    // Table from reset: reqs for the cycle and the outputs visible during it.
    vecs[0] = '{r0:0, r1:0, e_resp0:32, e_resp1:32, e_count:32, e_can1:1, e_can2:1, e_err:0, chk_r1:0};
    vecs[1] = '{r0:1, r1:1, e_resp0:32, e_resp1:33, e_count:32, e_can1:1, e_can2:1, e_err:0, chk_r1:1};
    vecs[2] = '{r0:0, r1:1, e_resp0:34, e_resp1:34, e_count:30, e_can1:1, e_can2:1, e_err:0, chk_r1:1};
    vecs[3] = '{r0:0, r1:0, e_resp0:35, e_resp1:35, e_count:29, e_can1:1, e_can2:1, e_err:0, chk_r1:1};
    vecs[4] = '{r0:1, r1:0, e_resp0:35, e_resp1:36, e_count:29, e_can1:1, e_can2:1, e_err:0, chk_r1:1};
    vecs[5] = '{r0:0, r1:0, e_resp0:36, e_resp1:36, e_count:28, e_can1:1, e_can2:1, e_err:0, chk_r1:1};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].r0, vecs[i].r1, 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("vec%0d_resp0", i), int'(resp0), vecs[i].e_resp0);
      if (vecs[i].chk_r1) chk($sformatf("vec%0d_resp1", i), int'(resp1), vecs[i].e_resp1);
      chk($sformatf("vec%0d_count", i), int'(count), vecs[i].e_count);
      chk($sformatf("vec%0d_can1", i), int'(can1), int'(vecs[i].e_can1));
      chk($sformatf("vec%0d_can2", i), int'(can2), int'(vecs[i].e_can2));
      chk($sformatf("vec%0d_err", i), int'(err), int'(vecs[i].e_err));
      tick();
    end

    // Run down to one entry, then an over-request must leave the head alone.
    idle();
    repeat (27) begin
      r0 = 1'b1;
      tick();
    end
    idle();
    #1;
    chk("last1_count", int'(count), 1);
    chk("last1_can2", int'(can2), 0);
    chk("last1_resp0", int'(resp0), 63);
    drive(1, 1, 0, 0, 0, 0, 0);
    tick();
    idle();
    #1;
    chk("underflow_count", int'(count), 1);
    chk("underflow_resp0", int'(resp0), 63);
    chk("underflow_err", int'(err), 1);

    // Empty pool; two same-cycle frees become allocatable next cycle in slot order.
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    idle();
    #1;
    chk("empty_count", int'(count), 0);
    chk("empty_can1", int'(can1), 0);
    drive(0, 0, 1, 5, 1, 7, 0);
    #1;
    chk("free_same_cycle_count", int'(count), 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("refill_count", int'(count), 2);
    chk("refill_resp0", int'(resp0), 5);
    chk("refill_resp1", int'(resp1), 7);
    chk("err_sticky", int'(err), 1);
    idle();

    // A free into a full pool is dropped and flagged; reset then clears the flag.
    do_reset();
    chk("rst_err", int'(err), 0);
    chk("rst_count", int'(count), 32);
    drive(0, 0, 1, 3, 0, 0, 0);
    tick();
    idle();
    #1;
    chk("overflow_err", int'(err), 1);
    chk("overflow_count", int'(count), 32);
    chk("overflow_resp0", int'(resp0), 32);

    // Allocate four, commit one, flush: head rewinds to the committed point.
    do_reset();
    drive(1, 1, 0, 0, 0, 0, 0);
    tick();
    tick();
    drive(0, 0, 1, 50, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    idle();
    #1;
    chk("flush_resp0", int'(resp0), 33);
    chk("flush_count", int'(count), 32);
    chk("flush_err", int'(err), 0);

    // Flush with a same-cycle request and commit: request ignored, commit kept.
    drive(1, 1, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 1, 9, 0, 0, 1);
    tick();
    idle();
    #1;
    chk("flush_mix_resp0", int'(resp0), 34);
    chk("flush_mix_count", int'(count), 32);
    chk("flush_mix_err", int'(err), 0);
    repeat (31) begin
      r0 = 1'b1;
      tick();
    end
    idle();
    #1;
    chk("flush_mix_freed_preg", int'(resp0), 9);
    chk("flush_mix_tail_count", int'(count), 1);

    // Random traffic against the model.
    do_reset();
    model_init();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit a0, a1, v0, v1, f, rst;
      int p0, p1, fsz, ssz;
      fsz = free_q.size();
      ssz = spec_q.size();
      if ($urandom_range(99) < 90) begin
        a0 = ($urandom_range(1) == 1) && (fsz >= 1);
        a1 = ($urandom_range(1) == 1) && (fsz >= 1 + int'(a0));
      end else begin
        a0 = $urandom_range(1) == 1;
        a1 = $urandom_range(1) == 1;
      end
      if ($urandom_range(99) < 95) begin
        v0 = ($urandom_range(1) == 1) && (ssz >= 1);
        v1 = ($urandom_range(1) == 1) && (ssz >= 1 + int'(v0));
      end else begin
        v0 = $urandom_range(1) == 1;
        v1 = $urandom_range(1) == 1;
      end
      p0  = int'($urandom_range(63));
      p1  = int'($urandom_range(63));
      f   = $urandom_range(24) == 0;
      rst = $urandom_range(399) == 0;
      drive(a0, a1, v0, p0, v1, p1, f);
      reset_i = rst;
      #1;
      chk("rnd_count", int'(count), free_q.size());
      chk("rnd_can1", int'(can1), int'(free_q.size() >= 1));
      chk("rnd_can2", int'(can2), int'(free_q.size() >= 2));
      chk("rnd_err", int'(err), int'(m_err));
      if (free_q.size() >= 1) chk("rnd_resp0", int'(resp0), free_q[0]);
      if (a0 && free_q.size() >= 2) chk("rnd_resp1", int'(resp1), free_q[1]);
      else if (!a0 && free_q.size() >= 1) chk("rnd_resp1", int'(resp1), free_q[0]);
      tick();
      model_step(rst, a0, a1, v0, p0, v1, p1, f);
    end
    reset_i = 1'b0;
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
